uart_rx_ecc_fifo: RTL and testbench
===================================

// Module: uart_rx_ecc_fifo
// PURPOSE
// UART receiver with configurable frame length and optional Hamming(12,8) single-error correction.
// Adds 3-sample majority voting, stop-bit framing check, per-word status flags, and a FIFO output buffer.
// The FIFO presents words on a valid/ready interface. Sits between the rx pin and the consumer FSM.
// PARAMETERS
// CYCLES_PER_BIT  434  clk_50M cycles per bit (115200 baud); must be >= 8
// ECC_EN          1    1: 12-bit Hamming codeword per frame; 0: plain 8-bit data per frame
// FIFO_DEPTH      4    output FIFO entries; power of 2, >= 2
// INJECT_EN       0    1: invert the received bit at index INJECT_IDX (debug fault injection)
// INJECT_IDX      6    codeword bit index inverted when INJECT_EN=1
// PORTS
// clk_50M          in   1  system clock
// rst              in   1  synchronous, active-high reset
// rx               in   1  asynchronous serial line, idle high
// rx_bit_dbg       out  1  last voted data bit (debugger)
// rx_data          out  8  FIFO head data
// rx_corrected     out  1  FIFO head: single-bit error was corrected
// rx_uncorrectable out  1  FIFO head: syndrome 13..15, data passed uncorrected
// rx_frame_err     out  1  FIFO head: stop bit sampled low
// rx_valid         out  1  FIFO non-empty
// rx_ready         in   1  consumer accepts head when rx_valid && rx_ready
// rx_overrun       out  1  1-cycle pulse: word dropped because FIFO full
// BEHAVIOUR
// - Reset value of all outputs, FIFO pointers, counters and flags is 0, except FIFO count = 0.
//   rx synchronisers reset to 1; state resets to IDLE.
// - Reset mid-frame aborts the frame; no partial word is written.
// - rx passes through a 2-FF synchroniser; all logic uses the synchronised value s_rx.
// - Frame: start(0), NB data bits LSB/index-0 first, stop(1). NB=12 if ECC_EN else 8.
// - FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
//   IDLE: cnt=0, idx=0; s_rx==0 -> START.
//   START: count to (CYCLES_PER_BIT-1)/2; if s_rx==0 -> DATA with cnt=0, else IDLE (glitch reject).
//   DATA: at cnt = CPB-3, CPB-2 and CPB-1, sample s_rx. At CPB-1, the bit is the majority of the 3 samples.
//     Store it to cw[idx] and rx_bit_dbg, then set cnt=0. If idx==NB-1 -> STOP, else idx++.
//   STOP: voted bit at cnt=CPB-1. frame_err = ~bit. Launch decode. -> IDLE if bit=1, else WAIT_HIGH.
//   WAIT_HIGH: stay until s_rx==1, then -> IDLE (prevents break retriggering).
// - Decode (ECC_EN=1), registered one cycle after the stop sample:
//   P1 = ^cw[0,2,4,6,8,10]; P2 = ^cw[1,2,5,6,9,10]; P3 = ^cw[3,4,5,6,11]; P4 = ^cw[7,8,9,10,11].
//   S = {P4,P3,P2,P1}.
//   S==0: no error. S in 1..12: flip cw[S-1], set corrected=1. S in 13..15: no flip, set uncorrectable=1.
//   Data map: d[0..7] = cw[11],cw[10],cw[9],cw[8],cw[6],cw[5],cw[4],cw[2].
//   ECC_EN=0: d = cw[7:0]; corrected and uncorrectable are always 0.
// - FIFO write occurs in the decode cycle (stop sample + 1).
//   rx_valid rises on stop sample + 2 when the FIFO was empty.
// - Write when full: word dropped, rx_overrun pulses once, FIFO contents unchanged.
//   Simultaneous pop and push when full: the pop frees the slot, so the push succeeds and there is no overrun.
// - Outputs are registered FIFO head values; they are stable while rx_valid && !rx_ready.
//   Read and write pointers wrap modulo FIFO_DEPTH.
// TESTING
// 1. ECC_EN=1, send codeword 0xA27 (data 0xA5). Expect rx_data=0xA5, corrected=0, uncorrectable=0, frame_err=0.
// 2. Send 0xA27 with cw[6] flipped (0xA67). Expect rx_data=0xA5, corrected=1.
// 3. Send 0xA27 with cw[11] and cw[0] flipped (0x226). S=13: expect uncorrectable=1, corrected=0, data uncorrected.
// 4. Send 5 frames with rx_ready=0 and FIFO_DEPTH=4. Expect rx_overrun to pulse once on frame 5.
//    Then drain to get frames 1-4 in order.
// 5. Send frame 0xA27 with stop=0, then hold the line low 3 bit times.
//    Expect frame_err=1 and a single word; no new frame until the line returns high.
// 6. Apply a 100-cycle low glitch on idle rx. Expect no word.
//    Assert rst mid-DATA: expect rx_valid=0 and state IDLE the next cycle.

Source files
------------

// File: rtl/uart_rx_ecc_fifo_if.sv
// Received-word bus between the UART receiver FIFO and its consumer.
interface uart_rx_ecc_fifo_if;
    logic [7:0] rx_data;
    logic       rx_corrected;
    logic       rx_uncorrectable;
    logic       rx_frame_err;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_overrun;

    modport master (
        output rx_data, rx_corrected, rx_uncorrectable, rx_frame_err, rx_valid, rx_overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_corrected, rx_uncorrectable, rx_frame_err, rx_valid, rx_overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_ecc_fifo.sv
// UART receiver with 3-sample majority voting, optional Hamming(12,8) correction
// and a small output FIFO presenting decoded words on a valid/ready bus.
module uart_rx_ecc_fifo #(
    parameter int CYCLES_PER_BIT = 434,
    parameter int ECC_EN         = 1,
    parameter int FIFO_DEPTH     = 4,
    parameter int INJECT_EN      = 0,
    parameter int INJECT_IDX     = 6
) (
    input  logic                       clk_50M,
    input  logic                       rst,
    input  logic                       rx,
    output logic                       rx_bit_dbg,
    uart_rx_ecc_fifo_if.master         words
);

    localparam int NB    = (ECC_EN != 0) ? 12 : 8;
    localparam int CNT_W = $clog2(CYCLES_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_HALF = cnt_t'((CYCLES_PER_BIT - 1) / 2);
    localparam cnt_t CNT_S0   = cnt_t'(CYCLES_PER_BIT - 3);
    localparam cnt_t CNT_S1   = cnt_t'(CYCLES_PER_BIT - 2);
    localparam cnt_t CNT_LAST = cnt_t'(CYCLES_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       corrected;
        logic       uncorrectable;
        logic       frame_err;
    } word_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic word_t decode_word(input logic [11:0] cw, input logic frame_err);
        logic [3:0]  syn;
        logic [11:0] fixed;
        word_t       w;
        w           = '0;
        w.frame_err = frame_err;
        syn         = '0;
        fixed       = cw;
        if (ECC_EN != 0) begin
            syn[0] = ^{cw[0], cw[2], cw[4], cw[6], cw[8], cw[10]};
            syn[1] = ^{cw[1], cw[2], cw[5], cw[6], cw[9], cw[10]};
            syn[2] = ^{cw[3], cw[4], cw[5], cw[6], cw[11]};
            syn[3] = ^{cw[7], cw[8], cw[9], cw[10], cw[11]};
            // Syndromes 13..15 point outside the codeword: flag only, never flip.
            if (syn >= 4'd13) begin
                w.uncorrectable = 1'b1;
            end else if (syn != 4'd0) begin
                fixed       = cw ^ (12'd1 << (syn - 4'd1));
                w.corrected = 1'b1;
            end
            w.data = {fixed[2], fixed[4], fixed[5], fixed[6],
                      fixed[8], fixed[9], fixed[10], fixed[11]};
        end else begin
            w.data = cw[7:0];
        end
        return w;
    endfunction

    // ---- stage: rx synchroniser ----
    logic rx_meta;
    logic s_rx;

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            rx_meta <= 1'b1;
            s_rx    <= 1'b1;
        end else begin
            rx_meta <= rx;
            s_rx    <= rx_meta;
        end
    end

    // ---- stage p0: bit timing, voting and frame assembly ----
    state_t      state;
    cnt_t        cnt;
    logic [3:0]  idx;
    logic [1:0]  samp;
    logic [11:0] cw;
    logic [11:0] cw_p0;
    logic        ferr_p0;
    logic        vld_p0;
    logic        bit_vote;
    logic        inject_hit;
    logic        rx_bit_in;

    assign bit_vote   = majority3(samp[0], samp[1], s_rx);
    assign inject_hit = (INJECT_EN != 0) && (idx == 4'(INJECT_IDX));
    assign rx_bit_in  = bit_vote ^ inject_hit;

    always_ff @(posedge clk_50M) begin
        vld_p0 <= 1'b0;
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            rx_bit_dbg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!s_rx) state <= START;
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= s_rx ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + cnt_t'(1);
                    end
                end
                DATA, STOP: begin
                    if (cnt == CNT_S0) samp[0] <= s_rx;
                    if (cnt == CNT_S1) samp[1] <= s_rx;
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (state == DATA) begin
                            cw[idx]    <= rx_bit_in;
                            rx_bit_dbg <= bit_vote;
                            if (idx == 4'(NB - 1)) state <= STOP;
                            else                   idx   <= idx + 4'd1;
                        end else begin
                            vld_p0  <= 1'b1;
                            cw_p0   <= cw;
                            ferr_p0 <= ~bit_vote;
                            // A low stop bit may be a break; wait for idle before rearming.
                            state   <= bit_vote ? IDLE : WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + cnt_t'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (s_rx) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---- stage p1: decode and FIFO write ----
    word_t              mem [FIFO_DEPTH];
    word_t              dec_word;
    word_t              head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               overrun;
    logic               full;
    logic               valid;
    logic               pop;
    logic               accept;

    assign dec_word = decode_word(cw_p0, ferr_p0);
    assign full     = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign valid    = (count != '0);
    assign pop      = valid && words.rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the word.
    assign accept   = vld_p0 && (!full || pop);

    always_ff @(posedge clk_50M) begin
        if (!rst && accept) mem[wr_ptr] <= dec_word;
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= vld_p0 && full && !pop;
            if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
            case ({accept, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // ---- output: FIFO head, zeroed while empty ----
    assign head                   = mem[rd_ptr];
    assign words.rx_valid         = valid;
    assign words.rx_data          = valid ? head.data : 8'd0;
    assign words.rx_corrected     = valid & head.corrected;
    assign words.rx_uncorrectable = valid & head.uncorrectable;
    assign words.rx_frame_err     = valid & head.frame_err;
    assign words.rx_overrun       = overrun;

endmodule

// File: tb/tb_uart_rx_ecc_fifo.sv
// Scoreboard bench for uart_rx_ecc_fifo: a serial driver queues expected words,
// a monitor pops and compares whenever the FIFO head is accepted.
module tb_uart_rx_ecc_fifo;

    localparam int CPB   = 24;
    localparam int DEPTH = 4;
    localparam int FRAME = 14 * CPB;

    logic clk_50M = 1'b0;
    logic rst;
    logic rx;
    logic rx_bit_dbg;

    uart_rx_ecc_fifo_if bus();

    uart_rx_ecc_fifo #(
        .CYCLES_PER_BIT(CPB),
        .ECC_EN(1),
        .FIFO_DEPTH(DEPTH),
        .INJECT_EN(0),
        .INJECT_IDX(6)
    ) dut (
        .clk_50M(clk_50M),
        .rst(rst),
        .rx(rx),
        .rx_bit_dbg(rx_bit_dbg),
        .words(bus.master)
    );

    always #5 clk_50M = ~clk_50M;

    int          checks     = 0;
    int          failures   = 0;
    int          ovr_seen   = 0;
    int          ovr_exp    = 0;
    int          ready_mode = 0;
    logic [10:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: syndrome is the XOR of the 1-based positions of all set bits;
    // data occupies the non-power-of-two positions, read from the top down.
    function automatic logic [10:0] model_word(input logic [11:0] cw, input logic stop);
        int          s;
        int          k;
        logic [11:0] c;
        logic [7:0]  d;
        logic        corr;
        logic        unc;
        s = 0; k = 0; c = cw; d = '0; corr = 1'b0; unc = 1'b0;
        for (int i = 0; i < 12; i++) if (c[i]) s = s ^ (i + 1);
        if (s >= 13) unc = 1'b1;
        else if (s != 0) begin
            c[s-1] = ~c[s-1];
            corr   = 1'b1;
        end
        for (int p = 12; p >= 1; p--) begin
            if ((p & (p - 1)) != 0) begin
                d[k] = c[p-1];
                k++;
            end
        end
        return {d, corr, unc, ~stop};
    endfunction

    function automatic logic [11:0] model_encode(input logic [7:0] d);
        logic [11:0] c;
        int          k;
        int          s;
        c = '0; k = 0; s = 0;
        for (int p = 12; p >= 1; p--) begin
            if ((p & (p - 1)) != 0) begin
                c[p-1] = d[k];
                k++;
            end
        end
        for (int i = 0; i < 12; i++) if (c[i]) s = s ^ (i + 1);
        for (int b = 1; b <= 8; b = b * 2) c[b-1] = ((s & b) != 0);
        return c;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50M);
        #1;
    endtask

    task automatic drive_frame(input logic [11:0] cw, input logic stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 12; i++) begin
            rx = cw[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
    endtask

    task automatic send(input logic [11:0] cw, input logic stop, input logic [10:0] exp,
                        input logic push, input int gap);
        if (push) exp_q.push_back(exp);
        drive_frame(cw, stop);
        rx = 1'b1;
        tick(gap);
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20 * FRAME) begin
            tick(1);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Consumer ready: held low, held high, or random per cycle.
    initial begin
        bus.rx_ready = 1'b0;
        forever begin
            @(posedge clk_50M);
            #1;
            case (ready_mode)
                0:       bus.rx_ready = 1'b0;
                1:       bus.rx_ready = 1'b1;
                default: bus.rx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares accepted head words and checks head stability under backpressure.
    initial begin
        logic        hold;
        logic [10:0] hold_word;
        logic [10:0] got;
        hold = 1'b0;
        hold_word = '0;
        forever begin
            @(negedge clk_50M);
            if (rst) begin
                hold = 1'b0;
            end else begin
                got = {bus.rx_data, bus.rx_corrected, bus.rx_uncorrectable, bus.rx_frame_err};
                if (hold) begin
                    check("hold_valid", bus.rx_valid, 1);
                    check("hold_word", got, hold_word);
                end
                if (bus.rx_overrun) ovr_seen++;
                if (bus.rx_valid && bus.rx_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_word actual=%0h required=none", got);
                    end else begin
                        check("word", got, exp_q.pop_front());
                    end
                end
                hold      = bus.rx_valid && !bus.rx_ready;
                hold_word = got;
            end
        end
    end

    initial begin
        logic [11:0] cw;
        logic        stop;
        int          nerr;
        int          p1;
        int          p2;

        rst = 1'b1;
        rx  = 1'b1;
        tick(5);
        check("rst_valid", bus.rx_valid, 0);
        check("rst_data", bus.rx_data, 0);
        check("rst_flags", {bus.rx_corrected, bus.rx_uncorrectable, bus.rx_frame_err}, 0);
        check("rst_overrun", bus.rx_overrun, 0);
        check("rst_dbg", rx_bit_dbg, 0);
        rst = 1'b0;
        tick(5);

        // Directed codewords: clean, single error, syndrome 13.
        ready_mode = 1;
        send(12'hA27, 1'b1, {8'hA5, 3'b000}, 1'b1, 10);
        wait_empty("clean_empty");
        check("clean_dbg", rx_bit_dbg, 1);
        send(12'hA67, 1'b1, {8'hA5, 3'b100}, 1'b1, 10);
        wait_empty("single_err_empty");
        send(12'h226, 1'b1, {8'hA4, 3'b010}, 1'b1, 10);
        wait_empty("uncorrectable_empty");
        check("uncorrectable_dbg", rx_bit_dbg, 0);

        // Five frames into a four-entry FIFO with no consumer.
        ready_mode = 0;
        tick(2);
        for (int i = 0; i < 5; i++) begin
            cw = model_encode(8'($urandom));
            if (i < DEPTH) send(cw, 1'b1, model_word(cw, 1'b1), 1'b1, 8);
            else begin
                ovr_exp++;
                send(cw, 1'b1, '0, 1'b0, 8);
            end
        end
        tick(10);
        check("full_valid", bus.rx_valid, 1);
        check("overrun_once", ovr_seen, 1);
        ready_mode = 1;
        wait_empty("drain_empty");

        // Low stop bit followed by a held-low line.
        exp_q.push_back({8'hA5, 3'b001});
        drive_frame(12'hA27, 1'b0);
        tick(3 * CPB);
        check("break_one_word", exp_q.size(), 0);
        rx = 1'b1;
        tick(4 * CPB);
        check("break_idle_valid", bus.rx_valid, 0);

        // Short low glitch on an idle line.
        rx = 1'b0;
        tick(6);
        rx = 1'b1;
        tick(2 * FRAME);
        check("glitch_valid", bus.rx_valid, 0);

        // Reset in the middle of a data phase, with a word already queued.
        ready_mode = 0;
        send(12'hA27, 1'b1, {8'hA5, 3'b000}, 1'b1, 10);
        tick(5);
        check("pre_reset_valid", bus.rx_valid, 1);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 5; i++) begin
            rx = 1'((i + 1) & 1);
            tick(CPB);
        end
        rst = 1'b1;
        rx  = 1'b1;
        exp_q.delete();
        tick(1);
        check("mid_reset_valid", bus.rx_valid, 0);
        check("mid_reset_data", bus.rx_data, 0);
        rst = 1'b0;
        ready_mode = 1;
        tick(2 * FRAME);
        check("post_reset_valid", bus.rx_valid, 0);
        send(12'hA67, 1'b1, {8'hA5, 3'b100}, 1'b1, 10);
        wait_empty("post_reset_empty");

        // Random data, 0..2 bit errors, occasional low stop bit, random consumer.
        ready_mode = 2;
        for (int i = 0; i < 24; i++) begin
            cw   = model_encode(8'($urandom));
            nerr = $urandom_range(0, 2);
            p1   = $urandom_range(0, 11);
            p2   = (p1 + $urandom_range(1, 11)) % 12;
            if (nerr >= 1) cw[p1] = ~cw[p1];
            if (nerr == 2) cw[p2] = ~cw[p2];
            stop = ($urandom_range(0, 7) != 0);
            send(cw, stop, model_word(cw, stop), 1'b1, $urandom_range(4, 30));
        end
        wait_empty("random_empty");

        tick(20);
        check("overrun_total", ovr_seen, ovr_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
